// File: rtl/pq_stream_driver.sv
// Command front end for the BRAM heap priority queue: filters push/pop/replace
// requests against a local occupancy count, strobes the queue and enforces its settle gap.
// Optional PQ_DRV_SHADOW_CHECK_EN adds a sticky o_shadow_err cross-check of q_full/q_empty.
module pq_stream_driver #(
  parameter int QUEUE_SIZE = 7,
  parameter int DATA_WIDTH = 16,
  parameter int OP_GAP     = 4,
  localparam int CW        = $clog2(QUEUE_SIZE + 1)
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [1:0]            s_op,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  q_wrt,
  output logic                  q_read,
  output logic [DATA_WIDTH-1:0] q_data,
  input  logic                  q_full,
  input  logic                  q_empty,
  input  logic [DATA_WIDTH-1:0] q_top,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CW-1:0]         o_count,
`ifdef PQ_DRV_SHADOW_CHECK_EN
  output logic                  o_shadow_err,
`endif
  output logic                  o_err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic [1:0]    OP_PUSH = 2'b01;
  localparam logic [1:0]    OP_POP  = 2'b10;
  localparam logic [1:0]    OP_REPL = 2'b11;
  localparam logic [CW-1:0] CNT_FULL = CW'(QUEUE_SIZE);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [3:0]    GAP_LOAD = 4'(OP_GAP);

  state_t                state_r;
  logic [1:0]            op_r;
  logic [3:0]            gap_r;
  logic [CW-1:0]         count_r;
  logic                  q_wrt_r;
  logic                  q_read_r;
  logic [DATA_WIDTH-1:0] q_data_r;
  logic                  m_valid_r;
  logic [DATA_WIDTH-1:0] m_data_r;
  logic                  err_r;
  logic                  accept_s;

  assign s_ready  = (state_r == ST_IDLE) && !m_valid_r;
  assign accept_s = s_valid && s_ready;

  assign q_wrt   = q_wrt_r;
  assign q_read  = q_read_r;
  assign q_data  = q_data_r;
  assign m_valid = m_valid_r;
  assign m_data  = m_data_r;
  assign o_count = count_r;
  assign o_err   = err_r;

  // Command FSM: request decode, strobe issue, settle gap and result register.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_r   <= ST_IDLE;
      op_r      <= 2'b00;
      gap_r     <= 4'd0;
      count_r   <= CNT_ZERO;
      q_wrt_r   <= 1'b0;
      q_read_r  <= 1'b0;
      q_data_r  <= {DATA_WIDTH{1'b0}};
      m_valid_r <= 1'b0;
      m_data_r  <= {DATA_WIDTH{1'b0}};
      err_r     <= 1'b0;
    end else begin
      err_r    <= 1'b0;
      q_wrt_r  <= 1'b0;
      q_read_r <= 1'b0;
      if (m_valid_r && m_ready) begin
        m_valid_r <= 1'b0;
      end
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            case (s_op)
              OP_PUSH: begin
                if (count_r == CNT_FULL) begin
                  err_r <= 1'b1;
                end else begin
                  q_wrt_r  <= 1'b1;
                  q_data_r <= s_data;
                  op_r     <= s_op;
                  state_r  <= ST_ISSUE;
                end
              end
              OP_POP, OP_REPL: begin
                if (count_r == CNT_ZERO) begin
                  err_r <= 1'b1;
                end else begin
                  // Root is read before the queue reorganises; it is the result.
                  q_wrt_r   <= (s_op == OP_REPL);
                  q_read_r  <= 1'b1;
                  q_data_r  <= s_data;
                  op_r      <= s_op;
                  m_data_r  <= q_top;
                  m_valid_r <= 1'b1;
                  state_r   <= ST_ISSUE;
                end
              end
              default: begin
                state_r <= ST_IDLE;
              end
            endcase
          end
        end
        ST_ISSUE: begin
          case (op_r)
            OP_PUSH: count_r <= count_r + CW'(1);
            OP_POP:  count_r <= count_r - CW'(1);
            default: count_r <= count_r;
          endcase
          gap_r   <= GAP_LOAD;
          state_r <= ST_GAP;
        end
        ST_GAP: begin
          if (gap_r <= 4'd1) begin
            gap_r   <= 4'd0;
            state_r <= ST_IDLE;
          end else begin
            gap_r <= gap_r - 4'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef PQ_DRV_SHADOW_CHECK_EN
  logic shadow_err_r;

  assign o_shadow_err = shadow_err_r;

  // Sticky cross-check of local occupancy against queue status, only while the status is settled.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      shadow_err_r <= 1'b0;
    end else if ((state_r == ST_IDLE) &&
                 (((count_r == CNT_FULL) != q_full) || ((count_r == CNT_ZERO) != q_empty))) begin
      shadow_err_r <= 1'b1;
    end else begin
      shadow_err_r <= shadow_err_r;
    end
  end
`else
  logic unused_status_s;

  assign unused_status_s = q_full ^ q_empty;
`endif

endmodule

// File: tb/tb_pq_stream_driver.sv
// Scoreboard bench for pq_stream_driver: directed requests push expected strobes,
// results and error pulses; a negedge monitor pops and compares them.
module tb_pq_stream_driver;

  localparam int QS = 7;
  localparam int DW = 16;
  localparam int GAP = 4;
  localparam int CW = 3;

  logic          CLK = 1'b0;
  logic          RSTn;
  logic          s_valid;
  logic          s_ready;
  logic [1:0]    s_op;
  logic [DW-1:0] s_data;
  logic          q_wrt;
  logic          q_read;
  logic [DW-1:0] q_data;
  logic          q_full;
  logic          q_empty;
  logic [DW-1:0] q_top;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [CW-1:0] o_count;
  logic          o_err;
`ifdef PQ_DRV_SHADOW_CHECK_EN
  logic          o_shadow_err;
`endif

  typedef struct packed {
    logic          w;
    logic          r;
    logic [DW-1:0] d;
  } strb_t;

  strb_t         strb_q[$];
  logic [DW-1:0] res_q[$];
  int            strobe_cyc[$];
  int            err_exp = 0;
  int            cnt_m = 0;
  int            qcnt = 0;
  int            cyc = 0;
  int            n_checks = 0;
  int            n_fail = 0;
  logic          force_ne = 1'b0;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] stall_data = '0;
  strb_t         mon_e;

  assign q_empty = force_ne ? 1'b0 : (qcnt == 0);
  assign q_full  = (qcnt == QS);

  pq_stream_driver #(.QUEUE_SIZE(QS), .DATA_WIDTH(DW), .OP_GAP(GAP)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .s_valid(s_valid), .s_ready(s_ready), .s_op(s_op), .s_data(s_data),
    .q_wrt(q_wrt), .q_read(q_read), .q_data(q_data),
    .q_full(q_full), .q_empty(q_empty), .q_top(q_top),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .o_count(o_count),
`ifdef PQ_DRV_SHADOW_CHECK_EN
    .o_shadow_err(o_shadow_err),
`endif
    .o_err(o_err)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic void chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Monitor: compares every strobe, result handshake and error pulse against the scoreboard.
  initial forever begin
    @(negedge CLK);
    if (RSTn) begin
      if (q_wrt || q_read) begin
        strobe_cyc.push_back(cyc);
        if (strb_q.size() == 0) begin
          chk("unexpected_strobe", 1, 0);
        end else begin
          mon_e = strb_q.pop_front();
          chk("q_wrt", q_wrt, mon_e.w);
          chk("q_read", q_read, mon_e.r);
          chk("q_data", q_data, mon_e.d);
          if (mon_e.w && !mon_e.r) qcnt++;
          if (mon_e.r && !mon_e.w) qcnt--;
        end
      end
      if (m_valid && m_ready) begin
        if (res_q.size() == 0) chk("unexpected_result", 1, 0);
        else chk("m_data", m_data, res_q.pop_front());
      end
      if (m_valid && !m_ready) begin
        if (stall_prev) chk("m_data_hold", m_data, stall_data);
        stall_prev = 1'b1;
        stall_data = m_data;
      end else begin
        stall_prev = 1'b0;
      end
      if (o_err) begin
        chk("o_err_expected", (err_exp > 0), 1);
        if (err_exp > 0) err_exp--;
      end
    end
  end

  task automatic do_req(input logic [1:0] op, input logic [DW-1:0] d);
    int n = 0;
    @(negedge CLK);
    while (!s_ready && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (!s_ready) begin
      chk("s_ready_timeout", 0, 1);
    end else begin
      case (op)
        2'b01: if (cnt_m == QS) err_exp++;
               else begin strb_q.push_back('{w: 1'b1, r: 1'b0, d: d}); cnt_m++; end
        2'b10: if (cnt_m == 0) err_exp++;
               else begin strb_q.push_back('{w: 1'b0, r: 1'b1, d: d}); res_q.push_back(q_top); cnt_m--; end
        2'b11: if (cnt_m == 0) err_exp++;
               else begin strb_q.push_back('{w: 1'b1, r: 1'b1, d: d}); res_q.push_back(q_top); end
        default: ;
      endcase
      s_valid = 1'b1;
      s_op    = op;
      s_data  = d;
      @(posedge CLK);
      #1;
      s_valid = 1'b0;
      s_op    = 2'b00;
      s_data  = '0;
    end
  endtask

  task automatic settle();
    repeat (GAP + 4) @(negedge CLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int c0;
    RSTn = 1'b0; s_valid = 1'b0; s_op = 2'b00; s_data = '0;
    m_ready = 1'b1; q_top = '0;
    #12;
    chk("rst_s_ready", s_ready, 1);
    chk("rst_q_wrt", q_wrt, 0);
    chk("rst_q_read", q_read, 0);
    chk("rst_q_data", q_data, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_o_count", o_count, 0);
    chk("rst_o_err", o_err, 0);
    @(negedge CLK);
    RSTn = 1'b1;

    // Pop on empty
    do_req(2'b10, 16'd0);
    settle();
    chk("empty_pop_count", o_count, 0);
    chk("empty_pop_m_valid", m_valid, 0);
    chk("empty_pop_err_seen", err_exp, 0);

    // Three pushes back to back
    base = strobe_cyc.size();
    do_req(2'b01, 16'd5);
    do_req(2'b01, 16'd3);
    do_req(2'b01, 16'd9);
    settle();
    chk("push_count", o_count, 3);
    chk("push_strobes", strobe_cyc.size() - base, 3);
    if (strobe_cyc.size() - base == 3) begin
      chk("push_spacing_1", strobe_cyc[base + 1] - strobe_cyc[base], GAP + 2);
      chk("push_spacing_2", strobe_cyc[base + 2] - strobe_cyc[base + 1], GAP + 2);
    end

    // Pop with root 3
    q_top = 16'd3;
    do_req(2'b10, 16'd0);
    settle();
    chk("pop_count", o_count, 2);
    chk("pop_result_taken", res_q.size(), 0);

    // Replace with a stalled result stream
    m_ready = 1'b0;
    q_top = 16'd5;
    do_req(2'b11, 16'd7);
    repeat (10) @(negedge CLK);
    chk("stall_s_ready", s_ready, 0);
    chk("stall_m_valid", m_valid, 1);
    chk("stall_m_data", m_data, 5);
    @(posedge CLK);
    #1 m_ready = 1'b1;
    settle();
    chk("repl_count", o_count, 2);
    chk("repl_result_taken", res_q.size(), 0);

    // Fill to capacity then overflow
    for (int i = 0; i < 5; i++) do_req(2'b01, DW'(10 + i));
    settle();
    chk("full_count", o_count, 7);
    do_req(2'b01, 16'd1);
    settle();
    chk("overflow_count", o_count, 7);
    chk("overflow_err_seen", err_exp, 0);
    chk("overflow_no_strobe", strb_q.size(), 0);

    // Reset while in GAP after a push
    q_top = 16'd1;
    do_req(2'b10, 16'd0);
    do_req(2'b01, 16'd4);
    repeat (2) @(posedge CLK);
    #1 RSTn = 1'b0;
    #1;
    chk("midrst_o_count", o_count, 0);
    chk("midrst_s_ready", s_ready, 1);
    chk("midrst_q_data", q_data, 0);
    chk("midrst_m_valid", m_valid, 0);
    chk("midrst_strobes", {q_wrt, q_read}, 0);
    cnt_m = 0;
    qcnt = 0;
    strb_q.delete();
    res_q.delete();
    err_exp = 0;
    @(posedge CLK);
    #1 RSTn = 1'b1;
    c0 = cyc;
    do_req(2'b01, 16'd6);
    chk("first_idle_accept", cyc - c0, 1);
    settle();
    chk("post_rst_count", o_count, 1);

`ifdef PQ_DRV_SHADOW_CHECK_EN
    q_top = 16'd6;
    do_req(2'b10, 16'd0);
    settle();
    chk("shadow_clean", o_shadow_err, 0);
    force_ne = 1'b1;
    repeat (3) @(negedge CLK);
    chk("shadow_set", o_shadow_err, 1);
    force_ne = 1'b0;
    repeat (3) @(negedge CLK);
    chk("shadow_sticky", o_shadow_err, 1);
`endif

    repeat (5) @(negedge CLK);
    chk("end_strobes_pending", strb_q.size(), 0);
    chk("end_results_pending", res_q.size(), 0);
    chk("end_errs_pending", err_exp, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
